// File: rtl/simt_divergence_unit_pkg.sv
// Shared types and constants for the SIMT divergence controller and its else-path LIFO.
// Latency: n/a (declarations only). Backpressure: n/a.
// The stack entry layout matches simt_stack so that entries pass straight through.
package simt_divergence_unit_pkg;

    localparam int DATA_WIDTH       = 32;
    localparam int WARP_SIZE        = 32;
    localparam int SIMT_STACK_DEPTH = 4;

    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ERR
    } simt_div_state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] reconvergence_pc;
        logic [WARP_SIZE-1:0]  active_mask;
        logic [WARP_SIZE-1:0]  taken_mask;
    } simt_stack_entry_t;

    // phase 0: taken path running; phase 1: not-taken path running
    typedef struct packed {
        logic [DATA_WIDTH-1:0] else_pc;
        logic                  phase;
    } simt_else_entry_t;

endpackage

// File: rtl/simt_else_lifo.sv
// Register LIFO of else-path PCs and phase bits, one entry per live divergence level.
// Latency: push/pop/set_phase take effect at the next clock; top is combinational.
// Backpressure: none; push when full and pop/set_phase when empty are ignored.
module simt_else_lifo
    import simt_divergence_unit_pkg::*;
#(
    parameter int DEPTH = SIMT_STACK_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       set_phase,
    input  simt_else_entry_t           push_entry,
    output simt_else_entry_t           top,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    simt_else_entry_t mem [DEPTH];
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    push_idx;
    logic             not_empty;
    logic             not_full;

    assign top_idx   = AW'(count - CW'(1));
    assign push_idx  = AW'(count);
    assign not_empty = (count != '0);
    assign not_full  = (count != CW'(DEPTH));
    assign top       = not_empty ? mem[top_idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (push && not_full) begin
            count <= count + CW'(1);
        end else if (pop && not_empty) begin
            count <= count - CW'(1);
        end
    end

    // Entry storage carries no reset; only the occupancy count defines validity.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push && not_full) begin
                mem[push_idx] <= push_entry;
            end else if (set_phase && !pop && not_empty) begin
                mem[top_idx].phase <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/simt_divergence_unit.sv
// Per-warp PC/active-mask sequencer driving simt_stack; optional stats under SIMT_DIV_STATS_EN.
// Latency: one cycle per accepted event or per reconvergence step; stack controls are combinational.
// Backpressure: br_ready = exec_valid; retire/exit/branch ignored while reconverging or outside RUN.
module simt_divergence_unit
    import simt_divergence_unit_pkg::*;
#(
    parameter int                    DEPTH   = SIMT_STACK_DEPTH,
    parameter logic [DATA_WIDTH-1:0] PC_STEP = simt_divergence_unit_pkg::PC_STEP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  launch,
    input  logic [DATA_WIDTH-1:0] launch_pc,
    input  logic [WARP_SIZE-1:0]  launch_mask,
    output logic                  exec_valid,
    output logic [DATA_WIDTH-1:0] exec_pc,
    output logic [WARP_SIZE-1:0]  exec_mask,
    input  logic                  retire,
    input  logic                  exit,
    input  logic                  br_valid,
    output logic                  br_ready,
    input  logic [DATA_WIDTH-1:0] br_pc,
    input  logic [DATA_WIDTH-1:0] br_target,
    input  logic [DATA_WIDTH-1:0] br_reconv_pc,
    input  logic [WARP_SIZE-1:0]  br_taken_mask,
    output logic                  stk_push,
    output logic                  stk_pop,
    output simt_stack_entry_t     stk_push_entry,
    output logic [DATA_WIDTH-1:0] stk_current_pc,
    input  simt_stack_entry_t     stk_top,
    input  logic                  stk_empty,
    input  logic                  stk_full,
    input  logic                  stk_at_reconv,
    output logic                  err
`ifdef SIMT_DIV_STATS_EN
    ,
    output logic [31:0]           stat_div_cnt,
    output logic [$clog2(DEPTH):0] stat_max_depth
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    simt_div_state_t       state, state_next;
    logic [DATA_WIDTH-1:0] pc, pc_next;
    logic [WARP_SIZE-1:0]  mask, mask_next;
    logic                  err_q, err_next;

    logic                  reconv_pending;
    logic                  br_fire;
    logic                  divergent;
    logic [WARP_SIZE-1:0]  t_mask;
    logic [WARP_SIZE-1:0]  n_mask;

    logic                  lifo_push;
    logic                  lifo_pop;
    logic                  lifo_set_phase;
    simt_else_entry_t      lifo_push_entry;
    simt_else_entry_t      lifo_top;
    logic [CW-1:0]         lifo_count;

    assign reconv_pending = !stk_empty && stk_at_reconv;
    assign t_mask         = br_taken_mask & mask;
    assign n_mask         = mask & ~br_taken_mask;
    assign divergent      = (t_mask != '0) && (n_mask != '0);

    assign exec_pc        = pc;
    assign exec_mask      = mask;
    assign stk_current_pc = pc;
    assign err            = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= '0;
            mask  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            mask  <= mask_next;
            err_q <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        mask_next  = mask;
        err_next   = err_q;
        unique case (state)
            IDLE: begin
                if (launch) begin
                    state_next = RUN;
                    pc_next    = launch_pc;
                    mask_next  = launch_mask;
                end
            end
            RUN: begin
                if (reconv_pending) begin
                    if (lifo_top.phase) begin
                        mask_next = stk_top.active_mask;
                    end else begin
                        mask_next = stk_top.active_mask & ~stk_top.taken_mask;
                        pc_next   = lifo_top.else_pc;
                    end
                end else if (exit) begin
                    if (stk_empty) begin
                        state_next = IDLE;
                        mask_next  = '0;
                    end else begin
                        state_next = ERR;
                        err_next   = 1'b1;
                    end
                end else if (br_fire) begin
                    if (t_mask == '0) begin
                        pc_next = pc + PC_STEP;
                    end else if (n_mask == '0) begin
                        pc_next = br_target;
                    end else if (stk_full) begin
                        state_next = ERR;
                        err_next   = 1'b1;
                    end else begin
                        mask_next = t_mask;
                        pc_next   = br_target;
                    end
                end else if (retire) begin
                    pc_next = pc + PC_STEP;
                end
            end
            ERR: begin
                state_next = ERR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Exit outranks a same-cycle branch, so a push is suppressed when exit is high.
    always_comb begin
        exec_valid      = (state == RUN) && !reconv_pending;
        br_ready        = exec_valid;
        br_fire         = br_valid && exec_valid;
        stk_push        = br_fire && !exit && divergent && !stk_full;
        stk_pop         = (state == RUN) && reconv_pending && lifo_top.phase;
        stk_push_entry  = '{reconvergence_pc: br_reconv_pc,
                            active_mask:      mask,
                            taken_mask:       t_mask};
        lifo_push       = stk_push;
        lifo_pop        = stk_pop;
        lifo_set_phase  = (state == RUN) && reconv_pending && !lifo_top.phase;
        lifo_push_entry = '{else_pc: br_pc + PC_STEP, phase: 1'b0};
    end

    simt_else_lifo #(
        .DEPTH (DEPTH)
    ) u_else_lifo (
        .clk        (clk),
        .rst        (rst),
        .push       (lifo_push),
        .pop        (lifo_pop),
        .set_phase  (lifo_set_phase),
        .push_entry (lifo_push_entry),
        .top        (lifo_top),
        .count      (lifo_count)
    );

`ifdef SIMT_DIV_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && launch)) begin
            stat_div_cnt   <= '0;
            stat_max_depth <= '0;
        end else if (stk_push) begin
            if (stat_div_cnt != '1) begin
                stat_div_cnt <= stat_div_cnt + 32'd1;
            end
            if ((lifo_count + CW'(1)) > stat_max_depth) begin
                stat_max_depth <= lifo_count + CW'(1);
            end
        end
    end
`endif

endmodule
